lcd_mux_scheduler: RTL and testbench

Time-multiplexing sequencer for a 4-COM, 1/3-bias static-segment LCD. It scans the common lines and selects, per COM and SEG pin, which of the four bias levels (V0..V3) the downstream pin mux applies. The four levels come from the existing duty-cycle level generator. Polarity is inverted every frame so the net DC across every pixel is zero. Pixel data is double-buffered and swapped only at frame boundaries, so writes never tear a frame.

---
 rtl/lcd_mux_scheduler_if.sv | 25 ++
 rtl/lcd_mux_scheduler.sv | 136 +++++++++++++
 tb/tb_lcd_mux_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lcd_mux_scheduler_if.sv
// Pin-mux bus for the LCD scan sequencer: control and pixel inputs, level-code outputs.
interface lcd_mux_scheduler_if #(
  parameter int COMS = 4,
  parameter int SEGS = 8
);

  logic                   Enable_i;
  logic [COMS*SEGS-1:0]   Data_i;
  logic                   Write_i;
  logic                   Pending_o;
  logic                   FrameStart_o;
  logic [2*COMS-1:0]      Com_o;
  logic [2*SEGS-1:0]      Seg_o;

  modport master (
    output Enable_i, Data_i, Write_i,
    input  Pending_o, FrameStart_o, Com_o, Seg_o
  );

  modport slave (
    input  Enable_i, Data_i, Write_i,
    output Pending_o, FrameStart_o, Com_o, Seg_o
  );

endinterface

// File: rtl/lcd_mux_scheduler.sv
// 4-COM, 1/3-bias LCD scan sequencer: eight slots per frame (four COMs at two
// polarities), frame-inverting drive, and a double-buffered pixel image that
// only swaps at frame boundaries.
module lcd_mux_scheduler #(
  parameter int COMS         = 4,
  parameter int SEGS         = 8,
  parameter int PHASE_CYCLES = 1024
) (
  input  logic                  Clock,
  input  logic                  Reset,
  lcd_mux_scheduler_if.slave    bus
);

  localparam int CW = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PHASE_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [2:0]            slot_q, slot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [COMS*SEGS-1:0]  shadow_q, shadow_d;
  logic [COMS*SEGS-1:0]  active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  frameStart_q, frameStart_d;
  logic [2*COMS-1:0]     com_q, com_d;
  logic [2*SEGS-1:0]     seg_q, seg_d;

  // Active COM is driven to the outer rail of the current polarity, idle COMs to the inner one.
  function automatic logic [2*COMS-1:0] comLevels(input logic [2:0] slot);
    logic [2*COMS-1:0] lv;
    lv = '0;
    for (int c = 0; c < COMS; c++) begin
      if (slot[1:0] == c[1:0]) lv[2*c +: 2] = slot[2] ? 2'd0 : 2'd3;
      else                     lv[2*c +: 2] = slot[2] ? 2'd2 : 2'd1;
    end
    return lv;
  endfunction

  // On segments sit opposite the active COM (3 units), off segments one unit away.
  function automatic logic [2*SEGS-1:0] segLevels(input logic [2:0] slot,
                                                  input logic [COMS*SEGS-1:0] img);
    logic [2*SEGS-1:0] lv;
    int                idx;
    lv = '0;
    for (int s = 0; s < SEGS; s++) begin
      idx = int'(slot[1:0]) * SEGS + s;
      if (img[idx]) lv[2*s +: 2] = slot[2] ? 2'd3 : 2'd0;
      else          lv[2*s +: 2] = slot[2] ? 2'd1 : 2'd2;
    end
    return lv;
  endfunction

  // Next-state: slot/counter sequencing, buffer swap at frame start, and registered level codes.
  always_comb begin
    logic load;
    load         = 1'b0;
    state_d      = state_q;
    slot_d       = slot_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frameStart_d = 1'b0;
    com_d        = com_q;
    seg_d        = seg_q;

    if (!bus.Enable_i) begin
      state_d = IDLE;
      slot_d  = '0;
      cnt_d   = '0;
      com_d   = '0;
      seg_d   = '0;
    end else begin
      state_d = RUN;
      if (state_q == IDLE) begin
        slot_d       = '0;
        cnt_d        = '0;
        load         = 1'b1;
        frameStart_d = 1'b1;
      end else if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) begin
          frameStart_d = 1'b1;
          load         = pending_q;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (load) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      com_d = comLevels(slot_d);
      seg_d = segLevels(slot_d, active_d);
    end

    if (bus.Write_i) begin
      shadow_d  = bus.Data_i;
      pending_d = 1'b1;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frameStart_q <= 1'b0;
      com_q        <= '0;
      seg_q        <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frameStart_q <= frameStart_d;
      com_q        <= com_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.Pending_o    = pending_q;
  assign bus.FrameStart_o = frameStart_q;
  assign bus.Com_o        = com_q;
  assign bus.Seg_o        = seg_q;

endmodule

// File: tb/tb_lcd_mux_scheduler.sv
// Scoreboard bench for lcd_mux_scheduler with 4-cycle slots and hand-tabulated
// level codes for each displayed image.
module tb_lcd_mux_scheduler;

  localparam int PC = 4;

  typedef struct {
    logic [7:0]  com;
    logic [15:0] seg;
    logic        pend;
    logic        fs;
  } expT;

  logic Clock = 1'b0;
  logic Reset;
  expT  sbQ[$];
  int   errors = 0;
  int   checks = 0;
  logic expPend;

  logic [7:0] comTab [8] = '{8'h57, 8'h5D, 8'h75, 8'hD5, 8'hA8, 8'hA2, 8'h8A, 8'h2A};

  lcd_mux_scheduler_if #(.COMS(4), .SEGS(8)) bus ();

  lcd_mux_scheduler #(.COMS(4), .SEGS(8), .PHASE_CYCLES(PC)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // Free-running 10-unit clock.
  always #5 Clock = ~Clock;

  // Expected Seg_o per slot for each image: 0 blank, 1 = 0x000000FF, 2 = 0xFF000000, 3 = 0x00000002.
  function automatic logic [15:0] segExp(input int img, input int slot);
    logic [15:0] v;
    v = (slot < 4) ? 16'hAAAA : 16'h5555;
    case (img)
      1: begin if (slot == 0) v = 16'h0000; if (slot == 4) v = 16'hFFFF; end
      2: begin if (slot == 3) v = 16'h0000; if (slot == 7) v = 16'hFFFF; end
      3: begin if (slot == 0) v = 16'hAAA2; if (slot == 4) v = 16'h555D; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic compareField(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] com, input logic [15:0] seg,
                             input logic pend, input logic fs);
    compareField({tag, ".Com_o"},        16'(bus.Com_o),        16'(com));
    compareField({tag, ".Seg_o"},        bus.Seg_o,             seg);
    compareField({tag, ".Pending_o"},    16'(bus.Pending_o),    16'(pend));
    compareField({tag, ".FrameStart_o"}, 16'(bus.FrameStart_o), 16'(fs));
  endtask

  // Drive inputs at a falling edge and queue the outputs required after the next rising edge.
  task automatic applyStimulus(input logic en, input logic wr, input logic [31:0] data,
                               input logic [7:0] com, input logic [15:0] seg,
                               input logic pend, input logic fs);
    expT e;
    bus.Enable_i = en;
    bus.Write_i  = wr;
    bus.Data_i   = data;
    e.com = com; e.seg = seg; e.pend = pend; e.fs = fs;
    sbQ.push_back(e);
    @(negedge Clock);
  endtask

  // One scanned frame showing image img, with up to two writes and an optional early stop.
  task automatic runFrame(input int img,
                          input int w1s, input int w1c, input logic [31:0] d1,
                          input int w2s, input int w2c, input logic [31:0] d2,
                          input int stopS, input int stopC);
    logic        wr;
    logic [31:0] d;
    logic        first;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < PC; c++) begin
        wr = 1'b0;
        d  = '0;
        if (s == w1s && c == w1c) begin wr = 1'b1; d = d1; end
        if (s == w2s && c == w2c) begin wr = 1'b1; d = d2; end
        first   = (s == 0 && c == 0);
        expPend = wr | (expPend & ~first);
        applyStimulus(1'b1, wr, d, comTab[s], segExp(img, s), expPend, first);
        if (s == stopS && c == stopC) return;
      end
    end
  endtask

  // Monitor: one rising edge after each queued stimulus, pop and compare.
  initial begin
    expT e;
    forever begin
      @(posedge Clock);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("scan", e.com, e.seg, e.pend, e.fs);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenario sequence.
  initial begin
    Reset        = 1'b0;
    bus.Enable_i = 1'b0;
    bus.Write_i  = 1'b0;
    bus.Data_i   = '0;
    expPend      = 1'b0;
    #1;
    checkOutput("reset", 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 16'h0000, 1'b0, 1'b0);

    runFrame(0, -1, -1, 32'h0, -1, -1, 32'h0, -1, -1);
    runFrame(0,  2,  1, 32'h000000FF, -1, -1, 32'h0, -1, -1);
    runFrame(1,  6,  0, 32'h000000FF, -1, -1, 32'h0, -1, -1);
    runFrame(1,  0,  0, 32'hFF000000, -1, -1, 32'h0, -1, -1);
    runFrame(2,  1,  2, 32'h00000001,  3,  0, 32'h00000002, -1, -1);

    runFrame(3, -1, -1, 32'h0, -1, -1, 32'h0, 5, 2);
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 16'h0000, expPend, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 16'h0000, expPend, 1'b0);
    runFrame(3, -1, -1, 32'h0, -1, -1, 32'h0, -1, -1);

    runFrame(3,  1,  0, 32'h00FF0000, -1, -1, 32'h0, 3, 1);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("asyncReset", 8'h00, 16'h0000, 1'b0, 1'b0);
    expPend = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    runFrame(0, -1, -1, 32'h0, -1, -1, 32'h0, -1, -1);

    @(negedge Clock);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
